// File: rtl/dcache_pkg.sv
// Shared types for the N-way dcache storage array: request opcodes, FSM states
// and an index-width helper.
package dcache_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP    = 2'd0,
    OP_WRITE_HIT = 2'd1,
    OP_FILL      = 2'd2,
    OP_INVAL     = 2'd3
  } dcache_op_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } dcache_state_e;

  // Index width for n entries; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_lru_age.sv
// True-LRU age update for one set: the touched way becomes age 0, and younger
// ways shift up by one. Also reports the way holding the oldest age.
module dcache_lru_age
  import dcache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int AW   = idx_w(WAYS)
) (
  input  logic [WAYS-1:0][AW-1:0] age_i,
  input  logic [AW-1:0]           touch_way_i,
  input  logic                    touch_i,
  output logic [WAYS-1:0][AW-1:0] age_o,
  output logic [AW-1:0]           oldest_o
);

  // Kept apart from the update so oldest_o has no path from touch_way_i.
  always_comb begin
    oldest_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_i[w] == AW'(WAYS - 1)) oldest_o = AW'(w);
    end
  end

  always_comb begin
    age_o = age_i;
    if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == touch_way_i) age_o[w] = '0;
        else if (age_i[w] < age_i[touch_way_i]) age_o[w] = age_i[w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage array with INIT sweep and registered responses.
// Optional macro DCACHE_BYTE_WRITE_EN adds be_i byte enables for WRITE_HIT.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int LINE_W = 256,
  parameter int TAG_W  = 23
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [$clog2(SETS)-1:0]   set_i,
  input  logic [TAG_W-1:0]          tag_i,
  input  logic [LINE_W-1:0]         data_i,
`ifdef DCACHE_BYTE_WRITE_EN
  input  logic [LINE_W/8-1:0]       be_i,
`endif
  output logic                      rsp_valid_o,
  output logic                      hit_o,
  output logic [$clog2(WAYS)-1:0]   hit_way_o,
  output logic [LINE_W-1:0]         data_o,
  output logic [TAG_W-1:0]          tag_o,
  output logic                      dirty_o,
  output logic                      wb_req_o
);

  localparam int AW = idx_w(WAYS);
  localparam int SW = idx_w(SETS);
  localparam int NB = LINE_W / 8;

  dcache_state_e state_reg, state_next;
  logic [SW-1:0] init_cnt_reg, init_cnt_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    if (state_reg == ST_INIT) begin
      init_cnt_next = init_cnt_reg + 1'b1;
      if (init_cnt_reg == SW'(SETS - 1)) state_next = ST_READY;
    end
  end

  assign req_ready_o = (state_reg == ST_READY);

  dcache_op_e op;
  logic       accept;
  assign op     = dcache_op_e'(req_op_i);
  assign accept = req_valid_i && req_ready_o && !rst_i;

  // Metadata stays in flops so all ways of a set can be compared in one cycle.
  logic [WAYS-1:0]             valid_mem [SETS];
  logic [WAYS-1:0]             dirty_mem [SETS];
  logic [WAYS-1:0][AW-1:0]     age_mem   [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_mem   [SETS];

  logic [WAYS-1:0]             set_valid, set_dirty;
  logic [WAYS-1:0][AW-1:0]     set_age, age_next, age_init;
  logic [WAYS-1:0][TAG_W-1:0]  set_tag;

  assign set_valid = valid_mem[set_i];
  assign set_dirty = dirty_mem[set_i];
  assign set_age   = age_mem[set_i];
  assign set_tag   = tag_mem[set_i];

  logic          hit_any, inv_found, touch, rsp_wb, be_any;
  logic [AW-1:0] hit_idx, inv_idx, oldest, victim, sel_way;
  logic [NB-1:0] wr_be;

  always_comb begin
    hit_any   = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (set_valid[w] && set_tag[w] == tag_i) begin
        hit_any = 1'b1;
        hit_idx = AW'(w);
      end
    end
    // Descending scan so the lowest invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) begin
        inv_found = 1'b1;
        inv_idx   = AW'(w);
      end
    end
  end

  assign victim  = inv_found ? inv_idx : oldest;
  assign sel_way = (op != OP_FILL && hit_any) ? hit_idx : victim;
  assign touch   = accept && ((op == OP_FILL) ||
                   (hit_any && (op == OP_LOOKUP || op == OP_WRITE_HIT)));

  always_comb begin
    rsp_wb = 1'b0;
    case (op)
      OP_LOOKUP: rsp_wb = !hit_any && set_valid[victim] && set_dirty[victim];
      OP_FILL:   rsp_wb = set_valid[victim] && set_dirty[victim];
      OP_INVAL:  rsp_wb = hit_any && set_dirty[hit_idx];
      default:   rsp_wb = 1'b0;
    endcase
  end

`ifdef DCACHE_BYTE_WRITE_EN
  assign wr_be  = (op == OP_FILL) ? '1 : be_i;
  assign be_any = |be_i;
`else
  assign wr_be  = '1;
  assign be_any = 1'b1;
`endif

  dcache_lru_age #(.WAYS(WAYS), .AW(AW)) u_lru (
    .age_i       (set_age),
    .touch_way_i (sel_way),
    .touch_i     (touch),
    .age_o       (age_next),
    .oldest_o    (oldest)
  );

  genvar gi;
  for (gi = 0; gi < WAYS; gi++) begin : g_age_init
    assign age_init[gi] = AW'(gi);
  end

  always_ff @(posedge clk_i) begin
    if (state_reg == ST_INIT) begin
      valid_mem[init_cnt_reg] <= '0;
      dirty_mem[init_cnt_reg] <= '0;
      age_mem[init_cnt_reg]   <= age_init;
    end else if (accept) begin
      age_mem[set_i] <= age_next;
      case (op)
        OP_WRITE_HIT: if (hit_any && be_any) dirty_mem[set_i][hit_idx] <= 1'b1;
        OP_FILL: begin
          tag_mem[set_i][victim]   <= tag_i;
          valid_mem[set_i][victim] <= 1'b1;
          dirty_mem[set_i][victim] <= 1'b0;
        end
        OP_INVAL: if (hit_any) valid_mem[set_i][hit_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Line data: one block RAM per way, read-before-write on the accepting edge.
  logic [WAYS-1:0][LINE_W-1:0] rd_bus;
  logic [WAYS-1:0]             data_we;

  for (gi = 0; gi < WAYS; gi++) begin : g_way
    logic [LINE_W-1:0] data_mem [SETS];
    logic [LINE_W-1:0] rd_data_reg;

    assign data_we[gi] = accept &&
        ((op == OP_WRITE_HIT && hit_any && hit_idx == AW'(gi)) ||
         (op == OP_FILL && victim == AW'(gi)));

    always_ff @(posedge clk_i) begin
      if (accept) rd_data_reg <= data_mem[set_i];
      for (int b = 0; b < NB; b++) begin
        if (data_we[gi] && wr_be[b]) data_mem[set_i][b*8 +: 8] <= data_i[b*8 +: 8];
      end
    end

    assign rd_bus[gi] = rd_data_reg;
  end

  logic [AW-1:0] rsp_way_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      hit_o       <= 1'b0;
      rsp_way_reg <= '0;
      tag_o       <= '0;
      dirty_o     <= 1'b0;
      wb_req_o    <= 1'b0;
    end else begin
      rsp_valid_o <= accept;
      if (accept) begin
        hit_o       <= (op != OP_FILL) && hit_any;
        rsp_way_reg <= sel_way;
        tag_o       <= set_tag[sel_way];
        dirty_o     <= set_dirty[sel_way];
        wb_req_o    <= rsp_wb;
      end
    end
  end

  assign hit_way_o = rsp_way_reg;
  assign data_o    = rsp_valid_o ? rd_bus[rsp_way_reg] : '0;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway (WAYS=4, SETS=16, LINE_W=256, TAG_W=23).
// Honours DCACHE_BYTE_WRITE_EN for the be_i port and byte-write expectation.
module tb_dcache_sram_nway;

  localparam logic [1:0] LOOKUP = 2'd0, WRITE_HIT = 2'd1, FILL = 2'd2, INVAL = 2'd3;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [3:0]   set_idx;
  logic [22:0]  req_tag;
  logic [255:0] wdata;
`ifdef DCACHE_BYTE_WRITE_EN
  logic [31:0]  be;
`endif
  logic         rsp_valid, hit, rdirty, wb;
  logic [1:0]   hit_way;
  logic [255:0] rdata;
  logic [22:0]  rtag;

  int n_checks = 0;
  int n_fails  = 0;

  dcache_sram_nway #(.WAYS(4), .SETS(16), .LINE_W(256), .TAG_W(23)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .set_i       (set_idx),
    .tag_i       (req_tag),
    .data_i      (wdata),
`ifdef DCACHE_BYTE_WRITE_EN
    .be_i        (be),
`endif
    .rsp_valid_o (rsp_valid),
    .hit_o       (hit),
    .hit_way_o   (hit_way),
    .data_o      (rdata),
    .tag_o       (rtag),
    .dirty_o     (rdirty),
    .wb_req_o    (wb)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [22:0] t);
    return {8{9'h0, t}};
  endfunction

  // One accepted request; returns 1ns after the accepting edge with the response visible.
  task automatic send(input logic [1:0] op, input logic [3:0] s, input logic [22:0] t,
                      input logic [255:0] d);
    req_valid = 1'b1;
    req_op    = op;
    set_idx   = s;
    req_tag   = t;
    wdata     = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    $display("txn op=%0d set=%0d tag=%0h -> hit=%0b way=%0d tag=%0h dirty=%0b wb=%0b",
             op, s, t, hit, hit_way, rtag, rdirty, wb);
    check_eq("rsp_valid", rsp_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [255:0] dead, wpat, exp_line;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = LOOKUP; set_idx = '0; req_tag = '0; wdata = '0;
`ifdef DCACHE_BYTE_WRITE_EN
    be = '1;
`endif
    dead = 256'hDEAD;
    wpat = {8{32'hCAFE_F00D}};
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", req_ready, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_hit", hit, 1'b0);
    check_eq("rst_hit_way", hit_way, 2'd0);
    check_eq("rst_data", rdata, 256'd0);
    check_eq("rst_tag", rtag, 23'd0);
    check_eq("rst_dirty", rdirty, 1'b0);
    check_eq("rst_wb", wb, 1'b0);

    // INIT sweep: ready low for 16 cycles; requests offered meanwhile are ignored.
    rst = 1'b0;
    req_valid = 1'b1;
    check_eq("init_ready_0", req_ready, 1'b0);
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("init_ready_%0d", i), req_ready, 1'b0);
      check_eq($sformatf("init_no_rsp_%0d", i), rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("init_rsp_dropped", rsp_valid, 1'b0);
    check_eq("ready_after_16", req_ready, 1'b1);

    send(LOOKUP, 4'd0, 23'h55, '0);
    check_eq("empty0_hit", hit, 1'b0);
    check_eq("empty0_way", hit_way, 2'd0);
    send(LOOKUP, 4'd15, 23'h7, '0);
    check_eq("empty15_hit", hit, 1'b0);
    check_eq("empty15_way", hit_way, 2'd0);
    check_eq("empty15_wb", wb, 1'b0);

    // LRU order in set 5
    send(FILL, 4'd5, 23'hA, mk(23'hA));
    check_eq("fillA_way", hit_way, 2'd0);
    send(FILL, 4'd5, 23'hB, mk(23'hB));
    check_eq("fillB_way", hit_way, 2'd1);
    send(FILL, 4'd5, 23'hC, mk(23'hC));
    send(FILL, 4'd5, 23'hD, mk(23'hD));
    check_eq("fillD_way", hit_way, 2'd3);
    send(LOOKUP, 4'd5, 23'hA, '0);
    check_eq("lookA_hit", hit, 1'b1);
    check_eq("lookA_way", hit_way, 2'd0);
    check_eq("lookA_data", rdata, mk(23'hA));
    send(FILL, 4'd5, 23'hE, mk(23'hE));
    check_eq("fillE_way", hit_way, 2'd1);
    check_eq("fillE_tag", rtag, 23'hB);
    check_eq("fillE_data", rdata, mk(23'hB));
    check_eq("fillE_hit", hit, 1'b0);
    check_eq("fillE_wb", wb, 1'b0);
    send(FILL, 4'd5, 23'hF, mk(23'hF));
    check_eq("fillF_way", hit_way, 2'd2);
    check_eq("fillF_tag", rtag, 23'hC);

    // Dirty eviction in set 2
    for (int i = 0; i < 4; i++) send(FILL, 4'd2, 23'(32'h20 + i), mk(23'(32'h20 + i)));
    send(WRITE_HIT, 4'd2, 23'h20, dead);
    check_eq("wh20_hit", hit, 1'b1);
    check_eq("wh20_way", hit_way, 2'd0);
    check_eq("wh20_dirty_pre", rdirty, 1'b0);
    for (int i = 1; i < 4; i++) send(LOOKUP, 4'd2, 23'(32'h20 + i), '0);
    send(FILL, 4'd2, 23'h24, mk(23'h24));
    check_eq("evict_way", hit_way, 2'd0);
    check_eq("evict_tag", rtag, 23'h20);
    check_eq("evict_data", rdata, dead);
    check_eq("evict_dirty", rdirty, 1'b1);
    check_eq("evict_wb", wb, 1'b1);

    // INVAL and invalid-first reuse in set 9
    for (int i = 0; i < 4; i++) send(FILL, 4'd9, 23'(32'h90 + i), mk(23'(32'h90 + i)));
    send(INVAL, 4'd9, 23'h92, '0);
    check_eq("inv92_hit", hit, 1'b1);
    check_eq("inv92_way", hit_way, 2'd2);
    check_eq("inv92_tag", rtag, 23'h92);
    check_eq("inv92_data", rdata, mk(23'h92));
    check_eq("inv92_wb", wb, 1'b0);
    send(FILL, 4'd9, 23'h94, mk(23'h94));
    check_eq("reuse_way", hit_way, 2'd2);
    check_eq("reuse_wb", wb, 1'b0);
    send(WRITE_HIT, 4'd9, 23'h93, wpat);
    send(INVAL, 4'd9, 23'h93, '0);
    check_eq("inv93_hit", hit, 1'b1);
    check_eq("inv93_dirty", rdirty, 1'b1);
    check_eq("inv93_wb", wb, 1'b1);
    send(INVAL, 4'd9, 23'h93, '0);
    check_eq("invmiss_hit", hit, 1'b0);
    check_eq("invmiss_wb", wb, 1'b0);
    check_eq("invmiss_way", hit_way, 2'd3);

    send(WRITE_HIT, 4'd10, 23'h1, wpat);
    check_eq("whmiss_hit", hit, 1'b0);
    check_eq("whmiss_wb", wb, 1'b0);

    // Back-to-back WRITE_HIT then LOOKUP in set 7
    send(FILL, 4'd7, 23'h70, mk(23'h70));
`ifdef DCACHE_BYTE_WRITE_EN
    be = 32'h1;
    exp_line = mk(23'h70);
    exp_line[7:0] = wpat[7:0];
`else
    exp_line = wpat;
`endif
    send(WRITE_HIT, 4'd7, 23'h70, wpat);
    check_eq("b2b_wh_hit", hit, 1'b1);
    send(LOOKUP, 4'd7, 23'h70, '0);
`ifdef DCACHE_BYTE_WRITE_EN
    be = '1;
`endif
    check_eq("b2b_hit", hit, 1'b1);
    check_eq("b2b_data", rdata, exp_line);
    check_eq("b2b_dirty", rdirty, 1'b1);

    // Re-init clears dirty contents; a request during the reset edge is dropped.
    for (int i = 0; i < 4; i++) send(FILL, 4'd3, 23'(32'h10 + i), mk(23'(32'h10 + i)));
    send(WRITE_HIT, 4'd3, 23'h11, dead);
    check_eq("s3_wh_hit", hit, 1'b1);
    rst = 1'b1; req_valid = 1'b1; req_op = LOOKUP; set_idx = 4'd3; req_tag = 23'h11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("rst_drop_rsp", rsp_valid, 1'b0);
    check_eq("rst_drop_ready", req_ready, 1'b0);
    rst = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check_eq("reinit_ready", req_ready, 1'b1);
    send(LOOKUP, 4'd3, 23'h11, '0);
    check_eq("reinit_hit", hit, 1'b0);
    check_eq("reinit_wb", wb, 1'b0);
    check_eq("reinit_way", hit_way, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
